// File: rtl/gmii_rx_frame_check.sv
// ---------------------------------------------------------------------------
// gmii_rx_frame_check
//
// Receive-side framing stage for one switch port. Consumes 8-bit GMII rx
// bytes (after the port adapter), strips preamble/SFD, and forwards the
// payload (first DA byte .. last FCS byte) to the switch core input pipeline
// with start/end-of-frame markers. At end of frame it reports the byte count
// and whether the frame must be discarded (rx error seen, runt or oversize).
// Per-port good/bad frame statistics are kept alongside.
//
// Ports
//   i_clk              GMII rx clock (125 MHz), sole clock
//   i_rst              asynchronous reset, active-high
//   i_gmii_dv          rx data valid
//   i_gmii_er          rx error
//   iv_gmii_rxd[7:0]   rx byte
//   ov_data[7:0]       payload byte, holds its last value
//   o_data_wr          ov_data valid this cycle (pulse)
//   o_sop              first payload byte of frame, qualified by o_data_wr
//   o_eop              last payload byte of frame, qualified by o_data_wr
//   o_frame_err        with o_eop: frame must be discarded downstream
//   ov_frame_len[10:0] with o_eop: payload byte count, saturates at 2047
//   ov_good_frame_cnt  frames ended without error, wraps
//   ov_bad_frame_cnt   frames ended in error or dropped, wraps
// ---------------------------------------------------------------------------
module gmii_rx_frame_check #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522,
    parameter int CNT_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_gmii_dv,
    input  logic             i_gmii_er,
    input  logic [7:0]       iv_gmii_rxd,
    output logic [7:0]       ov_data,
    output logic             o_data_wr,
    output logic             o_sop,
    output logic             o_eop,
    output logic             o_frame_err,
    output logic [10:0]      ov_frame_len,
    output logic [CNT_W-1:0] ov_good_frame_cnt,
    output logic [CNT_W-1:0] ov_bad_frame_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DROP
    } state_t;

    localparam logic [7:0]       PRE_BYTE = 8'h55;
    localparam logic [7:0]       SFD_BYTE = 8'hD5;
    localparam logic [10:0]      LEN_SAT  = 11'h7FF;
    localparam logic [10:0]      MIN_L    = 11'(MIN_LEN);
    localparam logic [10:0]      MAX_L    = 11'(MAX_LEN);
    localparam logic [2:0]       PRE_SAT  = 3'd7;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [2:0]       pre_cnt_q, pre_cnt_d;
    logic [10:0]      len_q, len_d;
    logic             er_seen_q, er_seen_d;
    logic [7:0]       hold_q, hold_d;

    logic [7:0]       data_q, data_d;
    logic             wr_q, wr_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic             err_q, err_d;
    logic [10:0]      flen_q, flen_d;
    logic [CNT_W-1:0] good_q, good_d;
    logic [CNT_W-1:0] bad_q, bad_d;

    // Verdict for the frame currently in DATA, used only on its final cycle.
    logic frame_bad;
    assign frame_bad = er_seen_q | (len_q < MIN_L) | (len_q > MAX_L);

    // The hold register is occupied exactly when len_q is non-zero, so no
    // separate valid flag is kept. len_q can never return to 1 once past it
    // (it saturates high), so len_q == 1 at emission marks the first byte.
    always_comb begin
        // NOTE: every variable gets a default here first so no path can infer a latch.
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        len_d     = len_q;
        er_seen_d = er_seen_q;
        hold_d    = hold_q;
        data_d    = data_q;
        flen_d    = flen_q;
        wr_d      = 1'b0;
        sop_d     = 1'b0;
        eop_d     = 1'b0;
        err_d     = 1'b0;
        good_d    = good_q;
        bad_d     = bad_q;

        case (state_q)
            S_IDLE: begin
                if (i_gmii_dv) begin
                    if (iv_gmii_rxd == PRE_BYTE) begin
                        state_d   = S_PREAMBLE;
                        pre_cnt_d = 3'd1;
                    end else begin
                        state_d = S_DROP;
                        bad_d   = bad_q + CNT_ONE;
                    end
                end
            end

            S_PREAMBLE: begin
                if (!i_gmii_dv) begin
                    // Carrier lost inside the preamble: not counted as a frame.
                    state_d = S_IDLE;
                end else if (i_gmii_er) begin
                    state_d = S_DROP;
                    bad_d   = bad_q + CNT_ONE;
                end else if (iv_gmii_rxd == PRE_BYTE) begin
                    if (pre_cnt_q != PRE_SAT) begin
                        pre_cnt_d = pre_cnt_q + 3'd1;
                    end
                end else if (iv_gmii_rxd == SFD_BYTE) begin
                    state_d   = S_DATA;
                    len_d     = 11'd0;
                    er_seen_d = 1'b0;
                end else begin
                    state_d = S_DROP;
                    bad_d   = bad_q + CNT_ONE;
                end
            end

            S_DATA: begin
                if (i_gmii_dv) begin
                    // Emit the previously held byte; the new one takes its place.
                    if (len_q != 11'd0) begin
                        wr_d   = 1'b1;
                        data_d = hold_q;
                        sop_d  = (len_q == 11'd1);
                    end
                    hold_d = iv_gmii_rxd;
                    if (len_q != LEN_SAT) begin
                        len_d = len_q + 11'd1;
                    end
                    if (i_gmii_er) begin
                        er_seen_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                    if (len_q == 11'd0) begin
                        // SFD immediately followed by end of carrier: empty frame.
                        bad_d = bad_q + CNT_ONE;
                    end else begin
                        wr_d   = 1'b1;
                        data_d = hold_q;
                        sop_d  = (len_q == 11'd1);
                        eop_d  = 1'b1;
                        err_d  = frame_bad;
                        flen_d = len_q;
                        if (frame_bad) begin
                            bad_d = bad_q + CNT_ONE;
                        end else begin
                            good_d = good_q + CNT_ONE;
                        end
                    end
                end
            end

            S_DROP: begin
                if (!i_gmii_dv) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A mid-frame reset abandons everything, including the held byte, so no
    // end-of-frame marker is ever produced for the interrupted frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            pre_cnt_q <= 3'd0;
            len_q     <= 11'd0;
            er_seen_q <= 1'b0;
            hold_q    <= 8'd0;
            data_q    <= 8'd0;
            wr_q      <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            err_q     <= 1'b0;
            flen_q    <= 11'd0;
            good_q    <= '0;
            bad_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            len_q     <= len_d;
            er_seen_q <= er_seen_d;
            hold_q    <= hold_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            err_q     <= err_d;
            flen_q    <= flen_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
        end
    end

    assign ov_data           = data_q;
    assign o_data_wr         = wr_q;
    assign o_sop             = sop_q;
    assign o_eop             = eop_q;
    assign o_frame_err       = err_q;
    assign ov_frame_len      = flen_q;
    assign ov_good_frame_cnt = good_q;
    assign ov_bad_frame_cnt  = bad_q;

endmodule
